p_tube_r1_port: RTL and testbench
=================================

# p_tube_r1_port

Parasite-side register port for the parasite-to-host byte channel of the Tube. It decodes parasite CPU accesses to the channel's data and status/control registers and stages written bytes in a small skid queue. It drains the queue into the parasite write side of the parasite-to-host FIFO one byte per clock whenever the FIFO is not full. It also provides CPU flow control (wait or drop-with-sticky-overflow) and a "queue drained" interrupt.

## Interface
- DEPTH, 4, skid queue depth; power of two, 2..8.
- WAIT_EN, 1, full-queue policy:
  - 1: stall the CPU with p_wait.
  - 0: drop the byte and set the overflow flag.

Ports:
- p_phi2  in  1  parasite clock; all state changes on the rising edge.
- p_rst  in  1  reset; asynchronous, active-high. Clears all state immediately.
- p_cs  in  1  register access strobe, high for exactly one p_phi2 cycle per access (held high while p_wait is high).
- p_rdnw  in  1  1 = read, 0 = write.
- p_addr  in  1  0 = data register, 1 = status/control register.
- p_din  in  8  CPU write data.
- p_dout  out  8  CPU read data, combinational from current state.
- p_wait  out  1  stall request to the CPU, combinational.
- p_irq  out  1  level interrupt, combinational from registered state.
- fifo_full  in  1  full flag from the FIFO write side.
- fifo_data  out  8  byte presented to the FIFO.
- fifo_select  out  1  FIFO write select; a write occurs on each p_phi2 edge where it is high.
- fifo_rdnw  out  1  constant 0.

## Operation
- Queue: DEPTH x 8 circular buffer.
  - Head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count of log2(DEPTH)+1 bits, range 0..DEPTH.
- push = p_cs & ~p_rdnw & ~p_addr & ~p_wait & (count<DEPTH | pop). The pushed byte is p_din.
- pop = (count!=0) & ~fifo_full.
- fifo_select = pop; fifo_data = queue[head].
  - Both are combinational, so a byte is never offered while fifo_full is high.
- Simultaneous push and pop is legal at any count, including count==DEPTH; count is unchanged.
- Full-queue write (data write with count==DEPTH and no pop that cycle):
  - WAIT_EN=1: p_wait=1 for every such cycle. The CPU holds the access and the byte is accepted on the first cycle a pop occurs.
  - WAIT_EN=0: p_wait stays 0, the byte is discarded, and overflow is set to 1 on that edge.
- Status read (p_addr=1, p_rdnw=1), p_dout bits:
  - bit7 = (count<DEPTH)
  - bit6 = overflow
  - bit5 = irq_en
  - bit4 = fifo_full
  - bits3:0 = count
- Data read (p_addr=0, p_rdnw=1): p_dout=8'h00, no side effects.
- p_dout is 8'h00 whenever p_cs=0.
- Control write (p_addr=1, p_rdnw=0):
  - irq_en <= p_din[0].
  - If p_din[7]=1, overflow <= 0. An overflow event in the same cycle wins (overflow stays 1).
- p_irq = irq_en & (count==0).

## Timing
- Reset values: queue empty, count=0, overflow=0, irq_en=0.
- Reset outputs: p_wait=0, p_irq=0, fifo_select=0, fifo_data=8'h00, p_dout=8'h00.
  - A status read directly after reset returns 8'h80.
- Latency: a byte written at edge n into an empty queue appears on fifo_data/fifo_select during cycle n+1. It is written to the FIFO at edge n+1 if fifo_full=0.
- Throughput: one byte per cycle in and one out, sustained.
- fifo_full rising stops draining in the same cycle. Queue contents are held until it falls.
- Reset mid-operation:
  - Queued bytes are lost.
  - fifo_select and p_wait drop asynchronously.
  - The FIFO's own contents are unaffected (it has a separate reset).

## Test plan
- Reset, then status read -> 8'h80; p_irq=0, fifo_select=0.
- fifo_full=0; write 8'h41, 8'h42, 8'h43 on consecutive cycles -> fifo_select high cycles n+1..n+3 with fifo_data 41, 42, 43; status returns 8'h80 afterwards.
- fifo_full=1, WAIT_EN=1:
  - Write 5 bytes 8'h10..8'h14 -> count reaches 4 (status 8'h14 with bit4 set), p_wait high on the 5th write.
  - Release fifo_full -> p_wait drops the same cycle; FIFO receives 10..14 in order.
- WAIT_EN=0, fifo_full=1:
  - Write 5 bytes -> 5th dropped, status 8'h54.
  - Control write 8'h80 -> status 8'h14.
- Control write 8'h01 with queue empty -> p_irq=1; write one byte with fifo_full=1 -> p_irq=0; release fifo_full -> p_irq=1 after drain.
- Assert p_rst with count=3 and fifo_full=0 -> fifo_select low immediately; status reads 8'h80 after release.

Source files
------------

// File: rtl/p_tube_r1_port.sv
// Parasite-side register port for the Tube parasite-to-host byte channel.
// CPU writes are staged in a small skid queue and drained into the FIFO one byte per clock.
module p_tube_r1_port #(
  parameter int DEPTH   = 4,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       p_phi2,
  input  logic       p_rst,
  input  logic       p_cs,
  input  logic       p_rdnw,
  input  logic       p_addr,
  input  logic [7:0] p_din,
  output logic [7:0] p_dout,
  output logic       p_wait,
  output logic       p_irq,
  input  logic       fifo_full,
  output logic [7:0] fifo_data,
  output logic       fifo_select,
  output logic       fifo_rdnw
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;

  logic data_wr, ctrl_wr, stat_rd;
  logic q_full, blocked, push, pop, drop;

  assign data_wr = p_cs & ~p_rdnw & ~p_addr;
  assign ctrl_wr = p_cs & ~p_rdnw &  p_addr;
  assign stat_rd = p_cs &  p_rdnw &  p_addr;

  // FIFO handshake: fifo_select is "valid", ~fifo_full is "ready"; a byte
  // transfers on every edge where both hold, and valid never rises while
  // ready is low, so select alone marks the transfer.
  assign q_full  = (count_q == FULL_CNT);
  assign pop     = (count_q != '0) & ~fifo_full;
  assign blocked = data_wr & q_full & ~pop;
  assign push    = data_wr & ~blocked;
  assign drop    = ~WAIT_EN & blocked;

  assign p_wait      = WAIT_EN & blocked;
  assign p_irq       = irq_en_q & (count_q == '0);
  assign fifo_select = pop;
  assign fifo_data   = mem_q[head_q];
  assign fifo_rdnw   = 1'b0;

  always_comb begin
    p_dout = 8'h00;
    if (stat_rd) begin
      p_dout = {~q_full, ovf_q, irq_en_q, fifo_full, 4'(count_q)};
    end
  end

  always_comb begin
    head_d   = pop  ? head_q + AW'(1) : head_q;
    tail_d   = push ? tail_q + AW'(1) : tail_q;
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    irq_en_d = ctrl_wr ? p_din[0] : irq_en_q;
    // A drop in the same cycle as a clear request leaves overflow set.
    ovf_d    = drop | (ovf_q & ~(ctrl_wr & p_din[7]));
  end

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (push) mem_q[tail_q] <= p_din;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
    end
  end

endmodule

// File: tb/tb_p_tube_r1_port.sv
// Bench for p_tube_r1_port: one instance per full-queue policy, checked each
// cycle against a queue-based behavioural model plus directed expectations.
module tb_p_tube_r1_port;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // index 0: WAIT_EN=1 instance, index 1: WAIT_EN=0 instance
  logic       cs   [2];
  logic       rdnw [2];
  logic       addr [2];
  logic [7:0] din  [2];
  logic       full [2];

  logic [7:0] dout_a, dout_b, fdata_a, fdata_b;
  logic       wait_a, wait_b, irq_a, irq_b, fsel_a, fsel_b, frdnw_a, frdnw_b;

  p_tube_r1_port #(.DEPTH(DEPTH), .WAIT_EN(1'b1)) dut_a (
    .p_phi2(clk), .p_rst(rst), .p_cs(cs[0]), .p_rdnw(rdnw[0]), .p_addr(addr[0]),
    .p_din(din[0]), .p_dout(dout_a), .p_wait(wait_a), .p_irq(irq_a),
    .fifo_full(full[0]), .fifo_data(fdata_a), .fifo_select(fsel_a), .fifo_rdnw(frdnw_a)
  );

  p_tube_r1_port #(.DEPTH(DEPTH), .WAIT_EN(1'b0)) dut_b (
    .p_phi2(clk), .p_rst(rst), .p_cs(cs[1]), .p_rdnw(rdnw[1]), .p_addr(addr[1]),
    .p_din(din[1]), .p_dout(dout_b), .p_wait(wait_b), .p_irq(irq_b),
    .fifo_full(full[1]), .fifo_data(fdata_b), .fifo_select(fsel_b), .fifo_rdnw(frdnw_b)
  );

  // scoreboard: bytes accepted but not yet handed to the FIFO, in order
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic       m_ovf [2];
  logic       m_ien [2];
  logic       last_wait [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  function automatic int msize(input int k);
    return (k == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic logic [7:0] mhead(input int k);
    return (k == 0) ? exp_q_a[0] : exp_q_b[0];
  endfunction

  function automatic void mpush(input int k, input logic [7:0] b);
    if (k == 0) exp_q_a.push_back(b);
    else        exp_q_b.push_back(b);
  endfunction

  function automatic void mpop(input int k);
    if (k == 0) void'(exp_q_a.pop_front());
    else        void'(exp_q_b.pop_front());
  endfunction

  function automatic void model_reset();
    exp_q_a.delete();
    exp_q_b.delete();
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 1'b0;
      m_ien[k] = 1'b0;
      last_wait[k] = 1'b0;
    end
  endfunction

  // what the queue rules say happens this cycle
  function automatic bit m_pop(input int k);
    return (msize(k) > 0) && !full[k];
  endfunction

  function automatic bit m_blocked(input int k);
    return cs[k] && !rdnw[k] && !addr[k] && (msize(k) == DEPTH) && !m_pop(k);
  endfunction

  function automatic logic [7:0] m_status(input int k);
    int sz = msize(k);
    return {sz < DEPTH, m_ovf[k], m_ien[k], full[k], 4'(sz)};
  endfunction

  task automatic check_outputs(input int k);
    logic [7:0] o_dout, o_fdata, e_dout;
    logic       o_wait, o_irq, o_fsel, o_frdnw;
    o_dout  = (k == 0) ? dout_a  : dout_b;
    o_fdata = (k == 0) ? fdata_a : fdata_b;
    o_wait  = (k == 0) ? wait_a  : wait_b;
    o_irq   = (k == 0) ? irq_a   : irq_b;
    o_fsel  = (k == 0) ? fsel_a  : fsel_b;
    o_frdnw = (k == 0) ? frdnw_a : frdnw_b;
    chk("fifo_select", k, 8'(o_fsel), 8'(m_pop(k)));
    if (msize(k) > 0) chk("fifo_data", k, o_fdata, mhead(k));
    chk("p_wait", k, 8'(o_wait), 8'((k == 0) && m_blocked(k)));
    chk("p_irq", k, 8'(o_irq), 8'(m_ien[k] && (msize(k) == 0)));
    chk("fifo_rdnw", k, 8'(o_frdnw), 8'h00);
    if (!(cs[k] && !rdnw[k])) begin
      e_dout = (cs[k] && rdnw[k] && addr[k]) ? m_status(k) : 8'h00;
      chk("p_dout", k, o_dout, e_dout);
    end
    last_wait[k] = o_wait;
  endtask

  function automatic void model_edge(input int k);
    bit pop, blocked, wr, ctrl;
    pop     = m_pop(k);
    blocked = m_blocked(k);
    wr      = cs[k] && !rdnw[k] && !addr[k];
    ctrl    = cs[k] && !rdnw[k] && addr[k];
    if (pop) mpop(k);
    if (wr && !blocked) mpush(k, din[k]);
    if (ctrl) begin
      m_ien[k] = din[k][0];
      if (din[k][7]) m_ovf[k] = 1'b0;
    end
    if (k == 1 && blocked) m_ovf[k] = 1'b1;
  endfunction

  // one clock: check at the falling edge, advance the model at the rising edge
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_outputs(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
  endtask

  // driver tasks
  task automatic set_idle(input int k);
    cs[k] = 1'b0; rdnw[k] = 1'b1; addr[k] = 1'b0; din[k] = 8'h00;
  endtask

  task automatic set_acc(input int k, input logic r, input logic a, input logic [7:0] d);
    cs[k] = 1'b1; rdnw[k] = r; addr[k] = a; din[k] = d;
  endtask

  task automatic wr_data(input int k, input logic [7:0] d);
    set_acc(k, 1'b0, 1'b0, d);
    step();
    set_idle(k);
  endtask

  task automatic wr_ctrl(input int k, input logic [7:0] d);
    set_acc(k, 1'b0, 1'b1, d);
    step();
    set_idle(k);
  endtask

  task automatic rd_status(input int k, input logic [7:0] exp);
    set_acc(k, 1'b1, 1'b1, 8'h00);
    #2;
    chk("status", k, (k == 0) ? dout_a : dout_b, exp);
    step();
    set_idle(k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      set_idle(k);
      full[k] = 1'b0;
    end
    model_reset();
    rst = 1'b1;
    #1;
    chk("rst_fifo_select", 0, 8'(fsel_a), 8'h00);
    chk("rst_p_wait", 0, 8'(wait_a), 8'h00);
    chk("rst_p_irq", 0, 8'(irq_a), 8'h00);
    chk("rst_fifo_data", 0, fdata_a, 8'h00);
    chk("rst_p_dout", 0, dout_a, 8'h00);
    chk("rst_fifo_data", 1, fdata_b, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    rd_status(0, 8'h80);
    rd_status(1, 8'h80);

    // back-to-back writes drain with one cycle of latency
    set_acc(0, 1'b0, 1'b0, 8'h41); step();
    set_acc(0, 1'b0, 1'b0, 8'h42); #2;
    chk("lat_sel", 0, 8'(fsel_a), 8'h01);
    chk("lat_data", 0, fdata_a, 8'h41);
    step();
    set_acc(0, 1'b0, 1'b0, 8'h43); #2;
    chk("lat_data", 0, fdata_a, 8'h42);
    step();
    set_idle(0); #2;
    chk("lat_data", 0, fdata_a, 8'h43);
    step(); step();
    rd_status(0, 8'h80);

    // WAIT_EN=1: fill while the FIFO is full, stall on the fifth byte
    full[0] = 1'b1;
    for (int i = 0; i < 4; i++) wr_data(0, 8'(8'h10 + i));
    rd_status(0, 8'h14);
    set_acc(0, 1'b0, 1'b0, 8'h14); #2;
    chk("stall", 0, 8'(wait_a), 8'h01);
    step(); step();
    full[0] = 1'b0; #2;
    chk("stall_release", 0, 8'(wait_a), 8'h00);
    step();
    set_idle(0);
    for (int i = 0; i < 6; i++) step();
    rd_status(0, 8'h80);

    // WAIT_EN=0: fifth byte dropped, overflow sticky until cleared
    full[1] = 1'b1;
    for (int i = 0; i < 5; i++) wr_data(1, 8'(8'h20 + i));
    rd_status(1, 8'h54);
    wr_ctrl(1, 8'h80);
    rd_status(1, 8'h14);
    full[1] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rd_status(1, 8'h80);

    // drained interrupt
    wr_ctrl(0, 8'h01); #2;
    chk("irq_empty", 0, 8'(irq_a), 8'h01);
    full[0] = 1'b1;
    wr_data(0, 8'h5a); #2;
    chk("irq_pending", 0, 8'(irq_a), 8'h00);
    full[0] = 1'b0;
    step(); #2;
    chk("irq_drained", 0, 8'(irq_a), 8'h01);
    step();

    // asynchronous reset with bytes queued
    full[0] = 1'b1;
    for (int i = 0; i < 3; i++) wr_data(0, 8'(8'h60 + i));
    full[0] = 1'b0; #2;
    chk("pre_rst_sel", 0, 8'(fsel_a), 8'h01);
    rst = 1'b1; #1;
    chk("async_rst_sel", 0, 8'(fsel_a), 8'h00);
    chk("async_rst_wait", 0, 8'(wait_a), 8'h00);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    rd_status(0, 8'h80);

    // randomized traffic on both instances, honouring the wait hold rule
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 5) == 0) full[k] = ~full[k];
        if (!last_wait[k]) begin
          if ($urandom_range(0, 1) == 1) begin
            cs[k]   = 1'b1;
            rdnw[k] = ($urandom_range(0, 2) == 0);
            addr[k] = ($urandom_range(0, 3) == 0);
            din[k]  = 8'($urandom_range(0, 255));
            if (addr[k] && !rdnw[k] && $urandom_range(0, 1) == 1) din[k][7] = 1'b0;
          end else begin
            set_idle(k);
          end
        end
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      set_idle(k);
      full[k] = 1'b0;
    end
    for (int i = 0; i < 8; i++) step();
    rd_status(0, {1'b1, m_ovf[0], m_ien[0], 5'b00000});
    rd_status(1, {1'b1, m_ovf[1], m_ien[1], 5'b00000});

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
